binary_divider_seq: RTL and testbench

//  Sequential restoring divider: computes quotient and remainder of unsigned a / b

---
 rtl/arith_pkg.sv | 22 ++
 rtl/div_step.sv | 21 ++
 rtl/binary_divider_seq.sv | 109 ++++++++++
 tb/tb_binary_divider_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: divider FSM encoding and a ceil-log2 helper.
package arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Smallest width able to represent values 0 .. v-1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
   parameter int unsigned k = 8
) (
   input  logic [k:0]   rem_i,
   input  logic         dvd_bit_i,
   input  logic [k-1:0] b_i,
   output logic [k:0]   rem_c_o,
   output logic         q_bit_c_o
);

   logic [k+1:0] shifted;

   // Keep the difference only when the shifted remainder covers the divisor.
   always_comb begin
      shifted   = {rem_i, dvd_bit_i};
      q_bit_c_o = (shifted >= (k+2)'(b_i));
      rem_c_o   = q_bit_c_o ? (k+1)'(shifted - (k+2)'(b_i)) : shifted[k:0];
   end

endmodule

// File: rtl/binary_divider_seq.sv
// Sequential restoring unsigned divider, one quotient bit per clock, start/busy/done handshake.
module binary_divider_seq
   import arith_pkg::*;
#(
   parameter int unsigned p = 8,
   parameter int unsigned k = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [p-1:0] a,
   input  logic [k-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [p-1:0] quotient,
   output logic [k-1:0] remainder,
   output logic         div_by_zero
);

   localparam int unsigned CW = clog2(p + 1);

   state_e         state_q;
   logic [CW-1:0]  cnt_q;
   logic [p-1:0]   dvd_q;      // dividend bits shift out the top, quotient bits shift in the bottom
   logic [k:0]     rem_q;
   logic [k-1:0]   b_q;
   logic           busy_q;
   logic           done_q;
   logic [p-1:0]   quotient_q;
   logic [k-1:0]   remainder_q;
   logic           dbz_q;

   logic [k:0]     step_rem;
   logic           step_q_bit;
   logic [p-1:0]   dvd_d;

   div_step #(.k(k)) u_step (
      .rem_i     (rem_q),
      .dvd_bit_i (dvd_q[p-1]),
      .b_i       (b_q),
      .rem_c_o   (step_rem),
      .q_bit_c_o (step_q_bit)
   );

   // Shift register contents after the current step.
   always_comb begin
      dvd_d = (dvd_q << 1) | p'(step_q_bit);
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         dvd_q       <= '0;
         rem_q       <= '0;
         b_q         <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_RUN: begin
               rem_q <= step_rem;
               dvd_q <= dvd_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q     <= ST_DONE;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  quotient_q  <= dvd_d;
                  remainder_q <= step_rem[k-1:0];
               end
            end
            default: begin
               if (start) begin
                  dvd_q <= a;
                  b_q   <= b;
                  rem_q <= '0;
                  dbz_q <= 1'b0;
                  if (b != '0) begin
                     state_q <= ST_RUN;
                     busy_q  <= 1'b1;
                     cnt_q   <= CW'(p);
                  end else begin
                     state_q     <= ST_DONE;
                     done_q      <= 1'b1;
                     quotient_q  <= '1;
                     remainder_q <= '0;
                     dbz_q       <= 1'b1;
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_binary_divider_seq.sv
// Scoreboard bench for binary_divider_seq: directed corner cases plus a random sweep.
module tb_binary_divider_seq;

   localparam int unsigned P = 8;
   localparam int unsigned K = 8;

   typedef struct {
      logic [P-1:0] q;
      logic [K-1:0] r;
      logic         dbz;
      int           due;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [P-1:0] a;
   logic [K-1:0] b;
   logic         busy;
   logic         done;
   logic [P-1:0] quotient;
   logic [K-1:0] remainder;
   logic         div_by_zero;

   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   binary_divider_seq #(.p(P), .k(K)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive one start pulse at a negedge and queue the reference result.
   task automatic issue(input logic [P-1:0] av, input logic [K-1:0] bv, output int lat);
      exp_t e;
      start = 1'b1;
      a     = av;
      b     = bv;
      if (bv == '0) begin
         lat   = 0;
         e.q   = '1;
         e.r   = '0;
         e.dbz = 1'b1;
      end else begin
         lat   = int'(P);
         e.q   = av / P'(bv);
         e.r   = K'(av % P'(bv));
         e.dbz = 1'b0;
      end
      e.due = cyc + 1 + lat;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      a     = P'($urandom);
      b     = K'($urandom);
   endtask

   // Issue and return at the negedge of the done cycle, ready for a back-to-back start.
   task automatic run_op(input logic [P-1:0] av, input logic [K-1:0] bv);
      int lat;
      issue(av, bv, lat);
      repeat (lat) @(negedge clk);
   endtask

   // Monitor: every result must appear exactly in its due cycle and nowhere else.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (done) begin
            if (sb.size() == 0) begin
               chk("spurious_done", 32'(done), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("done_cycle", 32'(cyc), 32'(e.due));
               chk("quotient", 32'(quotient), 32'(e.q));
               chk("remainder", 32'(remainder), 32'(e.r));
               chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            end
         end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("done_at_due", 32'(done), 32'd1);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int lat;
      start = 1'b0;
      a     = '0;
      b     = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_quotient", 32'(quotient), 32'd0);
      chk("rst_remainder", 32'(remainder), 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 100 / 7 with latency and busy window
      issue(8'd100, 8'd7, lat);
      chk("busy_after_accept", 32'(busy), 32'd1);
      repeat (lat) @(negedge clk);
      chk("busy_in_done", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      chk("hold_quotient", 32'(quotient), 32'd14);
      chk("hold_remainder", 32'(remainder), 32'd2);
      chk("idle_done_low", 32'(done), 32'd0);

      // Boundary cases, issued back-to-back
      run_op(8'd255, 8'd1);
      run_op(8'd5, 8'd9);
      run_op(8'd0, 8'd3);
      @(negedge clk);

      // Divide by zero, then a valid divide clears the flag at accept
      run_op(8'd200, 8'd0);
      repeat (2) @(negedge clk);
      chk("dbz_held", 32'(div_by_zero), 32'd1);
      chk("dbz_quotient_held", 32'(quotient), 32'hFF);
      issue(8'd100, 8'd7, lat);
      chk("dbz_cleared", 32'(div_by_zero), 32'd0);
      repeat (lat) @(negedge clk);
      @(negedge clk);

      // Start during RUN ignored; start in the DONE cycle accepted
      issue(8'd100, 8'd7, lat);
      repeat (2) @(negedge clk);
      start = 1'b1;
      a     = 8'd9;
      b     = 8'd2;
      @(negedge clk);
      start = 1'b0;
      a     = 8'd1;
      b     = 8'd1;
      repeat (lat - 3) @(negedge clk);
      run_op(8'd9, 8'd2);
      @(negedge clk);

      // Asynchronous reset mid-run aborts with no done pulse
      issue(8'd100, 8'd7, lat);
      repeat (3) @(negedge clk);
      #2;
      sb.delete();
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_quotient", 32'(quotient), 32'd0);
      chk("abort_remainder", 32'(remainder), 32'd0);
      chk("abort_dbz", 32'(div_by_zero), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (P + 4) @(negedge clk);
      chk("abort_busy_after", 32'(busy), 32'd0);

      // Random sweep, mixing back-to-back and gapped operations
      for (int i = 0; i < 1500; i++) begin
         logic [P-1:0] av;
         logic [K-1:0] bv;
         av = P'($urandom);
         if ($urandom_range(0, 1) == 0) bv = K'($urandom_range(1, 15));
         else                           bv = K'($urandom_range(1, 255));
         run_op(av, bv);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
